inst_ram_loader: RTL

Write-side companion to the instruction fetch port. It receives a little-endian byte stream on a valid/ready interface, typically from the boot UART. It assembles the bytes into 32-bit words and writes them sequentially through port 0 (RW) of the sky130 2 KB instruction SRAM, starting at word 0. The CPU fetch path is held off with `cpu_hold` while a load is in progress.

---
 rtl/inst_ram_pkg.sv | 23 ++
 rtl/inst_ram_loader_if.sv | 25 ++
 rtl/byte_word_packer.sv | 42 ++++
 rtl/inst_ram_loader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/inst_ram_pkg.sv
// Shared types and constants for the instruction-RAM loader.
// The CSUM state exists only when INST_LOADER_CSUM_EN is defined.
package inst_ram_pkg;

    localparam int         IRAM_DEPTH     = 512;
    localparam int         IRAM_ADDR_W    = 9;
    localparam int         IRAM_DATA_W    = 32;
    localparam logic [3:0] IRAM_WMASK_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_WRITE,
`ifdef INST_LOADER_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/inst_ram_loader_if.sv
// Byte-stream input plus SRAM port-0 write side of the instruction-RAM loader.
// master = loader view, slave = stream source / SRAM view.
interface inst_ram_loader_if;
    import inst_ram_pkg::*;

    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   csb0;
    logic                   web0;
    logic [3:0]             wmask0;
    logic [IRAM_ADDR_W-1:0] addr0;
    logic [IRAM_DATA_W-1:0] din0;

    modport master (
        input  in_valid, in_data,
        output in_ready, csb0, web0, wmask0, addr0, din0
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, csb0, web0, wmask0, addr0, din0
    );

endinterface

// File: rtl/byte_word_packer.sv
// Little-endian 8->32 packer: three bytes are held, the fourth is combined live
// so the full word is available on the same cycle word_valid pulses.
module byte_word_packer (
    input  logic        clk0,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shreg_q, shreg_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clr) begin
            cnt_d = '0;
        end else if (byte_en) begin
            cnt_d   = cnt_q + 2'd1;
            shreg_d = {byte_in, shreg_q[23:8]};
        end
    end

    assign word_valid = byte_en & ~clr & (cnt_q == 2'd3);
    assign word       = {byte_in, shreg_q};

    always_ff @(posedge clk0) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/inst_ram_loader.sv
// Streams a length-prefixed little-endian byte image into the instruction SRAM.
// Define INST_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module inst_ram_loader
    import inst_ram_pkg::*;
#(
    parameter int DEPTH  = IRAM_DEPTH,
    parameter int ADDR_W = IRAM_ADDR_W,
    parameter int DATA_W = IRAM_DATA_W
) (
    input  logic                clk0,
    input  logic                rst,
    input  logic                start,
    inst_ram_loader_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                cpu_hold
);

    localparam logic [15:0] DEPTH_N = 16'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              csb0_q, csb0_d;
    logic              web0_q, web0_d;
    logic [3:0]        wmask0_q, wmask0_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [DATA_W-1:0] din0_q, din0_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef INST_LOADER_CSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        accept, start_go, last_word, word_valid;
    logic [15:0] hdr_n;
    logic [31:0] word;

    assign accept    = bus.in_valid & in_ready_q;
    assign start_go  = start & (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign hdr_n     = {bus.in_data, n_q[7:0]};
    assign last_word = (16'(word_idx_q) == n_q - 16'd1);

    byte_word_packer u_packer (
        .clk0       (clk0),
        .rst        (rst),
        .clr        (start_go),
        .byte_en    (accept && state_q == ST_DATA),
        .byte_in    (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        csb0_d     = 1'b1;
        web0_d     = 1'b1;
        wmask0_d   = wmask0_q;
        addr0_d    = addr0_q;
        din0_d     = din0_q;
`ifdef INST_LOADER_CSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_go) begin
                    state_d    = ST_HDR0;
                    n_d        = '0;
                    word_idx_d = '0;
`ifdef INST_LOADER_CSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_HDR0: begin
                if (accept) begin
                    n_d[7:0] = bus.in_data;
                    state_d  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    n_d = hdr_n;
                    if (hdr_n == 16'd0) begin
`ifdef INST_LOADER_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end else if (hdr_n > DEPTH_N) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
`ifdef INST_LOADER_CSUM_EN
                    csum_d = csum_q ^ bus.in_data;
`endif
                    // Port-0 strobes are registered, so they are set up on the 4th byte.
                    if (word_valid) begin
                        state_d  = ST_WRITE;
                        csb0_d   = 1'b0;
                        web0_d   = 1'b0;
                        wmask0_d = IRAM_WMASK_ALL;
                        addr0_d  = word_idx_q;
                        din0_d   = DATA_W'(word);
                    end
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_q + 1'b1;
                if (last_word) begin
`ifdef INST_LOADER_CSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef INST_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_HDR0) || (state_d == ST_HDR1) || (state_d == ST_DATA)
`ifdef INST_LOADER_CSUM_EN
                     || (state_d == ST_CSUM)
`endif
                     ;
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
        busy_d = !(state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERR);
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            in_ready_q <= 1'b0;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            wmask0_q   <= '0;
            addr0_q    <= '0;
            din0_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef INST_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            in_ready_q <= in_ready_d;
            csb0_q     <= csb0_d;
            web0_q     <= web0_d;
            wmask0_q   <= wmask0_d;
            addr0_q    <= addr0_d;
            din0_q     <= din0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef INST_LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.csb0     = csb0_q;
    assign bus.web0     = web0_q;
    assign bus.wmask0   = wmask0_q;
    assign bus.addr0    = addr0_q;
    assign bus.din0     = din0_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_hold     = busy_q;

endmodule
